// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator port protocol.
// Bus vectors are declared [0:N-1], so bit 0 is the MSB.
package calc_pkg;

    localparam int unsigned CALC_DATA_W = 32;
    localparam int unsigned CMD_W       = 4;
    localparam int unsigned RESP_W      = 2;
    localparam int unsigned CNT_W       = 4;

    localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
    localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
    localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
    localparam logic [0:CMD_W-1] CMD_SHL = 4'd5;
    localparam logic [0:CMD_W-1] CMD_SHR = 4'd6;

    localparam logic [0:RESP_W-1] RESP_NONE = 2'd0;
    localparam logic [0:RESP_W-1] RESP_OK   = 2'd1;
    localparam logic [0:RESP_W-1] RESP_ERR  = 2'd2;
    localparam logic [0:RESP_W-1] RESP_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPND2    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_RESP_OUT = 2'd3
    } state_e;

endpackage

// File: rtl/calc_port_responder_if.sv
// Request/response signal bundle for one calculator port.
interface calc_port_responder_if
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = CALC_DATA_W
);
    logic [0:CMD_W-1]  req_cmd_in;
    logic [0:DATA_W-1] req_data_in;
    logic [0:RESP_W-1] out_resp;
    logic [0:DATA_W-1] out_data;
    logic              busy;
    logic              protocol_err;

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, protocol_err
    );

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, protocol_err
    );
endinterface

// File: rtl/calc_alu.sv
// Combinational execute stage: unsigned add/sub with range checks, logical shifts.
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = CALC_DATA_W
) (
    input  logic [0:CMD_W-1]  cmd,
    input  logic [0:DATA_W-1] op1,
    input  logic [0:DATA_W-1] op2,
    output logic [0:RESP_W-1] resp,
    output logic [0:DATA_W-1] result
);

    logic [0:DATA_W] sum;
    logic [4:0]      shamt;

    assign sum   = {1'b0, op1} + {1'b0, op2};
    assign shamt = op2[DATA_W-5:DATA_W-1];

    // Anything not explicitly handled (including out-of-range results) reports an error with zero data.
    always_comb begin
        resp   = RESP_ERR;
        result = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[0]) begin
                    resp   = RESP_OK;
                    result = sum[1:DATA_W];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp   = RESP_OK;
                    result = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp   = RESP_OK;
                result = op1 << shamt;
            end
            CMD_SHR: begin
                resp   = RESP_OK;
                result = op1 >> shamt;
            end
            default: begin
                resp   = RESP_ERR;
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calculator responder: two-cycle request capture, programmable
// wait, one-cycle registered response.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int unsigned RESP_DELAY = 1,
    parameter int unsigned DATA_W     = CALC_DATA_W
) (
    input  logic                  c_clk,
    input  logic                  reset_n,
    calc_port_responder_if.slave  bus
);

    state_e            state_q, state_d;
    logic [0:CMD_W-1]  cmd_q, cmd_d;
    logic [0:DATA_W-1] op1_q, op1_d;
    logic [0:DATA_W-1] op2_q, op2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:RESP_W-1] out_resp_q, out_resp_d;
    logic [0:DATA_W-1] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              perr_q, perr_d;

    logic [0:DATA_W-1] alu_op2;
    logic [0:RESP_W-1] alu_resp;
    logic [0:DATA_W-1] alu_result;

    // In OPND2 the operand is still on the bus; this lets a zero delay respond on the capture edge.
    assign alu_op2 = (state_q == ST_OPND2) ? bus.req_data_in : op2_q;

    calc_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (alu_op2),
        .resp   (alu_resp),
        .result (alu_result)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        cnt_d      = cnt_q;
        out_resp_d = RESP_NONE;
        out_data_d = '0;
        perr_d     = perr_q;

        if ((state_q == ST_OPND2 || state_q == ST_WAIT) && bus.req_cmd_in != CMD_NOP) begin
            perr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_cmd_in != CMD_NOP) begin
                    cmd_d   = bus.req_cmd_in;
                    op1_d   = bus.req_data_in;
                    state_d = ST_OPND2;
                end
            end
            ST_OPND2: begin
                op2_d = bus.req_data_in;
                if (RESP_DELAY == 0) begin
                    out_resp_d = alu_resp;
                    out_data_d = alu_result;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(RESP_DELAY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d      = '0;
                    out_resp_d = alu_resp;
                    out_data_d = alu_result;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP_OUT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NOP;
            op1_q      <= '0;
            op2_q      <= '0;
            cnt_q      <= '0;
            out_resp_q <= RESP_NONE;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            cnt_q      <= cnt_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
            busy_q     <= busy_d;
            perr_q     <= perr_d;
        end
    end

    assign bus.out_resp     = out_resp_q;
    assign bus.out_data     = out_data_q;
    assign bus.busy         = busy_q;
    assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench: one responder with RESP_DELAY=1 and one with RESP_DELAY=0 share stimulus.
module tb_calc_port_responder;
    import calc_pkg::*;

    logic c_clk = 1'b0;
    logic reset_n;
    always #5 c_clk = ~c_clk;

    calc_port_responder_if #(.DATA_W(32)) bus1 ();
    calc_port_responder_if #(.DATA_W(32)) bus0 ();

    calc_port_responder #(.RESP_DELAY(1), .DATA_W(32)) dut1 (
        .c_clk(c_clk), .reset_n(reset_n), .bus(bus1.slave));
    calc_port_responder #(.RESP_DELAY(0), .DATA_W(32)) dut0 (
        .c_clk(c_clk), .reset_n(reset_n), .bus(bus0.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] cmd, input logic [31:0] data);
        bus1.req_cmd_in  = cmd;
        bus1.req_data_in = data;
        bus0.req_cmd_in  = cmd;
        bus0.req_data_in = data;
    endtask

    task automatic tick();
        @(negedge c_clk);
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] perr1, input logic [31:0] perr0);
        chk({tag, " d1 resp"}, 32'(bus1.out_resp), 32'd0);
        chk({tag, " d1 data"}, 32'(bus1.out_data), 32'd0);
        chk({tag, " d1 busy"}, 32'(bus1.busy), 32'd0);
        chk({tag, " d1 perr"}, 32'(bus1.protocol_err), perr1);
        chk({tag, " d0 resp"}, 32'(bus0.out_resp), 32'd0);
        chk({tag, " d0 data"}, 32'(bus0.out_data), 32'd0);
        chk({tag, " d0 busy"}, 32'(bus0.busy), 32'd0);
        chk({tag, " d0 perr"}, 32'(bus0.protocol_err), perr0);
    endtask

    // Full transaction starting at a presentation negedge; ends at the next free presentation slot.
    task automatic txn(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [1:0] resp, input logic [31:0] data);
        set_in(cmd, op1);
        tick();
        chk({tag, " c1 d1 busy"}, 32'(bus1.busy), 32'd1);
        chk({tag, " c1 d0 busy"}, 32'(bus0.busy), 32'd1);
        set_in(4'd0, op2);
        tick();
        chk({tag, " c2 d0 resp"}, 32'(bus0.out_resp), 32'(resp));
        chk({tag, " c2 d0 data"}, 32'(bus0.out_data), data);
        chk({tag, " c2 d0 busy"}, 32'(bus0.busy), 32'd0);
        chk({tag, " c2 d1 resp"}, 32'(bus1.out_resp), 32'd0);
        chk({tag, " c2 d1 busy"}, 32'(bus1.busy), 32'd1);
        set_in(4'd0, $urandom);
        tick();
        chk({tag, " c3 d1 resp"}, 32'(bus1.out_resp), 32'(resp));
        chk({tag, " c3 d1 data"}, 32'(bus1.out_data), data);
        chk({tag, " c3 d1 busy"}, 32'(bus1.busy), 32'd0);
        chk({tag, " c3 d0 resp"}, 32'(bus0.out_resp), 32'd0);
        tick();
        chk({tag, " c4 d1 resp"}, 32'(bus1.out_resp), 32'd0);
        chk({tag, " c4 d1 data"}, 32'(bus1.out_data), 32'd0);
    endtask

    initial begin
        logic [31:0] sw_op1;

        vecs[0]  = '{4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
        vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[2]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
        vecs[3]  = '{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000};
        vecs[4]  = '{4'd2, 32'h0000_0010, 32'h0000_0010, 2'd1, 32'h0000_0000};
        vecs[5]  = '{4'd2, 32'h0000_0100, 32'h0000_0001, 2'd1, 32'h0000_00FF};
        vecs[6]  = '{4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002};
        vecs[7]  = '{4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
        vecs[8]  = '{4'd6, 32'h0000_00F0, 32'hFFFF_FFE4, 2'd1, 32'h0000_000F};
        vecs[9]  = '{4'd5, 32'h8000_0000, 32'h0000_0001, 2'd1, 32'h0000_0000};
        vecs[10] = '{4'd3, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[11] = '{4'd4, 32'h0000_0002, 32'h0000_0003, 2'd2, 32'h0000_0000};
        vecs[12] = '{4'd7, 32'h0000_0002, 32'h0000_0003, 2'd2, 32'h0000_0000};
        vecs[13] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};

        // Reset held with random inputs
        reset_n = 1'b0;
        set_in(4'($urandom), $urandom);
        for (int i = 0; i < 4; i++) begin
            tick();
            set_in(4'($urandom), $urandom);
        end
        chk_idle("in_reset", 32'd0, 32'd0);
        set_in(4'd0, 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk_idle("after_reset", 32'd0, 32'd0);

        for (int v = 0; v < 14; v++) begin
            txn($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].op1, vecs[v].op2,
                vecs[v].resp, vecs[v].data);
        end

        for (int b = 0; b < 31; b++) begin
            sw_op1 = 32'd1 << b;
            txn($sformatf("shl_sweep%0d", b), 4'd5, sw_op1, 32'hFFFF_FFE1, 2'd1, sw_op1 << 1);
        end

        // Back-to-back on the delay-1 port: B presented in A's response cycle
        set_in(4'd1, 32'd2); tick();
        set_in(4'd0, 32'd3); tick();
        chk("b2b A d0 resp", 32'(bus0.out_resp), 32'd1);
        chk("b2b A d0 data", 32'(bus0.out_data), 32'd5);
        set_in(4'd0, 32'd0); tick();
        chk("b2b A d1 resp", 32'(bus1.out_resp), 32'd1);
        chk("b2b A d1 data", 32'(bus1.out_data), 32'd5);
        set_in(4'd5, 32'd3); tick();
        chk("b2b B d1 busy", 32'(bus1.busy), 32'd1);
        set_in(4'd0, 32'd2); tick();
        chk("b2b B d0 resp", 32'(bus0.out_resp), 32'd1);
        chk("b2b B d0 data", 32'(bus0.out_data), 32'd12);
        set_in(4'd0, 32'd0); tick();
        chk("b2b B d1 resp", 32'(bus1.out_resp), 32'd1);
        chk("b2b B d1 data", 32'(bus1.out_data), 32'd12);
        tick();
        chk_idle("b2b end", 32'd0, 32'd0);

        // Back-to-back on the delay-0 port; same B lands in WAIT on the delay-1 port
        set_in(4'd2, 32'd9); tick();
        set_in(4'd0, 32'd4); tick();
        chk("wait_err A d0 resp", 32'(bus0.out_resp), 32'd1);
        chk("wait_err A d0 data", 32'(bus0.out_data), 32'd5);
        chk("wait_err pre d1 perr", 32'(bus1.protocol_err), 32'd0);
        set_in(4'd6, 32'h100); tick();
        chk("wait_err A d1 resp", 32'(bus1.out_resp), 32'd1);
        chk("wait_err A d1 data", 32'(bus1.out_data), 32'd5);
        chk("wait_err d1 perr", 32'(bus1.protocol_err), 32'd1);
        chk("wait_err d0 perr", 32'(bus0.protocol_err), 32'd0);
        set_in(4'd0, 32'd4); tick();
        chk("wait_err B d0 resp", 32'(bus0.out_resp), 32'd1);
        chk("wait_err B d0 data", 32'(bus0.out_data), 32'h10);
        chk("wait_err B d1 busy", 32'(bus1.busy), 32'd0);
        set_in(4'd0, 32'd0); tick();
        chk_idle("wait_err end", 32'd1, 32'd0);

        // Nonzero command during operand 2: word still taken as op2
        set_in(4'd1, 32'd5); tick();
        set_in(4'd1, 32'd7); tick();
        chk("opnd2_err d0 resp", 32'(bus0.out_resp), 32'd1);
        chk("opnd2_err d0 data", 32'(bus0.out_data), 32'd12);
        chk("opnd2_err d0 perr", 32'(bus0.protocol_err), 32'd1);
        set_in(4'd0, 32'd0); tick();
        chk("opnd2_err d1 resp", 32'(bus1.out_resp), 32'd1);
        chk("opnd2_err d1 data", 32'(bus1.out_data), 32'd12);
        tick();
        tick();
        chk_idle("opnd2_err sticky", 32'd1, 32'd1);

        // Reset mid-WAIT aborts the request
        set_in(4'd1, 32'd1); tick();
        set_in(4'd0, 32'd1); tick();
        chk("abort d1 busy pre", 32'(bus1.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort d1 busy async", 32'(bus1.busy), 32'd0);
        chk("abort d1 perr async", 32'(bus1.protocol_err), 32'd0);
        chk("abort d0 perr async", 32'(bus0.protocol_err), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort quiet%0d resp", i), 32'(bus1.out_resp), 32'd0);
            chk($sformatf("abort quiet%0d data", i), 32'(bus1.out_data), 32'd0);
        end
        chk_idle("abort end", 32'd0, 32'd0);

        txn("recover", 4'd1, 32'h0000_0010, 32'h0000_0020, 2'd1, 32'h0000_0030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
